// File: rtl/mysystem_ram_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   DEF_ADDR_W : default RAM word-address width (2048 words)
//   DEF_DATA_W : default data width
//   ret_tag_t  : return-tag record for an outstanding read (valid, owner)
package mysystem_ram_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic valid;
    logic owner;
  } ret_tag_t;

endpackage

// File: rtl/mysystem_rr_arb2.sv
// Two-way round-robin arbiter with its priority register.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   req[1:0]      : per-requester request
//   gnt_valid_c   : some requester is granted this cycle (combinational)
//   gnt_idx_c     : index of the granted requester (combinational)
module mysystem_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic       gnt_valid_c,
  output logic       gnt_idx_c
);

  logic prio_q;
  logic prio_d;

  // Grant decode; after a grant, priority moves to the loser.
  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = 1'b0;
    prio_d      = prio_q;
    case (req)
      2'b01:   gnt_idx_c = 1'b0;
      2'b10:   gnt_idx_c = 1'b1;
      2'b11:   gnt_idx_c = prio_q;
      default: gnt_idx_c = 1'b0;
    endcase
    if (gnt_valid_c) begin
      prio_d = ~gnt_idx_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mysystem_ram_arbiter.sv
// Arbitrates two Avalon-MM style requesters onto one synchronous RAM port.
// Grant is combinational (round-robin on contention); reads return exactly
// one cycle later, steered to the owner recorded in a return tag.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   mN_address/byteenable/read/write/writedata : requester N command (N=0,1)
//   mN_waitrequest                   : command N not accepted this cycle
//   mN_readdata/mN_readdatavalid     : read response to requester N
//   ram_address/byteenable/chipselect/write/clken/writedata : RAM command
//   ram_readdata                     : RAM read data (1-cycle latency)
module mysystem_ram_arbiter
  import mysystem_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_idx;
  logic       sel_write;
  ret_tag_t   tag_q;
  ret_tag_t   tag_d;

  // Read+write together counts as a request and is executed as a write.
  assign req = {m1_read | m1_write, m0_read | m0_write};

  mysystem_rr_arb2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .gnt_valid_c (gnt_valid),
    .gnt_idx_c   (gnt_idx)
  );

  // RAM command mux, waitrequests and next return tag.
  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    sel_write      = m0_write;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_clken      = reset_n;
    tag_d          = '0;
    if (gnt_idx) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      sel_write      = m1_write;
    end
    if (reset_n && gnt_valid) begin
      ram_chipselect = 1'b1;
      ram_write      = sel_write;
      tag_d.valid    = ~sel_write;
      tag_d.owner    = gnt_idx;
    end
    // Any request implies a grant, so a requester waits iff the other won.
    m0_waitrequest = ~reset_n | (req[0] & gnt_idx);
    m1_waitrequest = ~reset_n | (req[1] & ~gnt_idx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign m0_readdatavalid = tag_q.valid & ~tag_q.owner;
  assign m1_readdatavalid = tag_q.valid & tag_q.owner;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule
